// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bundle: the ALU result and decode inputs coming from EX,
// plus the registered MEM-side outputs, redirect/flush and exception signals.
interface ex_mem_stage_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int RD_W   = 4
);
  logic              in_valid;
  logic [1:0]        in_fc;
  logic [3:0]        func_c;
  logic [DATA_W-1:0] in_op;
  logic [DATA_W-1:0] in_r0;
  logic              in_flag;
  logic              in_oflw;
  logic [RD_W-1:0]   in_rd;
  logic [DATA_W-1:0] in_sdata;
  logic [PC_W-1:0]   in_tgt;
  logic [PC_W-1:0]   in_pc;
  logic              mem_stall;
  logic              exc_ack;

  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] out_r0;
  logic              out_reg_we;
  logic              out_r0_we;
  logic [RD_W-1:0]   out_rd;
  logic              out_mem_rd;
  logic              out_mem_wr;
  logic [DATA_W-1:0] out_wdata;
  logic              out_redirect;
  logic [PC_W-1:0]   out_tgt;
  logic              out_flush;
  logic              out_exc;
  logic [1:0]        out_cause;
  logic [PC_W-1:0]   out_epc;

  // Environment side: drives EX bundle, stall and acknowledge.
  modport master (
    output in_valid, in_fc, func_c, in_op, in_r0, in_flag, in_oflw, in_rd,
           in_sdata, in_tgt, in_pc, mem_stall, exc_ack,
    input  out_ready, out_valid, out_result, out_r0, out_reg_we, out_r0_we,
           out_rd, out_mem_rd, out_mem_wr, out_wdata, out_redirect, out_tgt,
           out_flush, out_exc, out_cause, out_epc
  );

  // Stage side.
  modport slave (
    input  in_valid, in_fc, func_c, in_op, in_r0, in_flag, in_oflw, in_rd,
           in_sdata, in_tgt, in_pc, mem_stall, exc_ack,
    output out_ready, out_valid, out_result, out_r0, out_reg_we, out_r0_we,
           out_rd, out_mem_rd, out_mem_wr, out_wdata, out_redirect, out_tgt,
           out_flush, out_exc, out_cause, out_epc
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with write-enable decode, branch/jump redirect,
// one-cycle flush and a held exception released by exc_ack.
module ex_mem_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int RD_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  ex_mem_stage_if.slave bus,
  output logic [1:0]  dbg_state
);
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    EXC   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Handshake: an EX instruction transfers on a clock edge where in_valid and
  // out_ready are both high and mem_stall is low; out_ready is only high in RUN
  // without a stall, so upstream must hold its instruction while it is low.
  logic accept;
  assign bus.out_ready = (state_q == RUN) && !bus.mem_stall;
  assign accept        = bus.in_valid && bus.out_ready;
  assign dbg_state     = state_q;

  logic dec_reg_we, dec_r0_we, dec_mem_rd, dec_mem_wr;
  logic dec_taken, dec_ovf, dec_illegal, fault;
  logic [1:0] fault_cause;

  always_comb begin
    dec_reg_we  = 1'b0;
    dec_r0_we   = 1'b0;
    dec_mem_rd  = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_taken   = 1'b0;
    dec_ovf     = 1'b0;
    dec_illegal = 1'b0;
    case (bus.in_fc)
      2'b00: begin
        case (bus.func_c)
          4'b0000, 4'b0001: begin
            dec_reg_we = !bus.in_oflw;
            dec_ovf    = bus.in_oflw;
          end
          4'b0010, 4'b0011, 4'b0100, 4'b1000, 4'b1001: dec_reg_we = 1'b1;
          4'b0101: begin
            dec_reg_we = 1'b1;
            dec_r0_we  = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b01: begin
        case (bus.func_c)
          4'b0000: begin
            dec_mem_rd = 1'b1;
            dec_reg_we = 1'b1;
          end
          4'b0001: dec_mem_wr = 1'b1;
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        if (bus.func_c[3:2] == 2'b00) dec_taken = bus.in_flag;
        else                          dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    fault       = dec_ovf || dec_illegal;
    fault_cause = dec_illegal ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.mem_stall) begin
      case (state_q)
        RUN: begin
          if (accept && fault)          state_d = EXC;
          else if (accept && dec_taken) state_d = FLUSH;
        end
        FLUSH:   state_d = RUN;
        EXC:     if (bus.exc_ack) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid    <= 1'b0;
      bus.out_result   <= '0;
      bus.out_r0       <= '0;
      bus.out_reg_we   <= 1'b0;
      bus.out_r0_we    <= 1'b0;
      bus.out_rd       <= '0;
      bus.out_mem_rd   <= 1'b0;
      bus.out_mem_wr   <= 1'b0;
      bus.out_wdata    <= '0;
      bus.out_redirect <= 1'b0;
      bus.out_tgt      <= '0;
      bus.out_flush    <= 1'b0;
      bus.out_exc      <= 1'b0;
      bus.out_cause    <= '0;
      bus.out_epc      <= '0;
    end else if (bus.mem_stall) begin
      // Freeze the MEM slot, but never let a redirect/flush pulse stretch.
      bus.out_redirect <= 1'b0;
      bus.out_flush    <= 1'b0;
    end else begin
      // Bubble by default; an accepted instruction overrides below.
      bus.out_valid    <= 1'b0;
      bus.out_reg_we   <= 1'b0;
      bus.out_r0_we    <= 1'b0;
      bus.out_mem_rd   <= 1'b0;
      bus.out_mem_wr   <= 1'b0;
      bus.out_redirect <= 1'b0;
      bus.out_flush    <= 1'b0;
      if (state_q == EXC && bus.exc_ack) bus.out_exc <= 1'b0;
      if (accept) begin
        bus.out_valid  <= 1'b1;
        bus.out_result <= bus.in_op;
        bus.out_r0     <= bus.in_r0;
        bus.out_rd     <= bus.in_rd;
        bus.out_wdata  <= bus.in_sdata;
        if (fault) begin
          bus.out_exc   <= 1'b1;
          bus.out_cause <= fault_cause;
          bus.out_epc   <= bus.in_pc;
          bus.out_flush <= 1'b1;
        end else begin
          bus.out_reg_we <= dec_reg_we;
          bus.out_r0_we  <= dec_r0_we;
          bus.out_mem_rd <= dec_mem_rd;
          bus.out_mem_wr <= dec_mem_wr;
          if (dec_taken) begin
            bus.out_redirect <= 1'b1;
            bus.out_flush    <= 1'b1;
            bus.out_tgt      <= bus.in_tgt;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: ALU writes, divide R0 write, taken branch
// flush, overflow and illegal exceptions, MEM stall hold and reset during EXC.
module tb_ex_mem_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         n_cmp = 0;
  int         n_err = 0;

  ex_mem_stage_if #(.DATA_W(16), .PC_W(16), .RD_W(4)) bus ();

  ex_mem_stage #(.DATA_W(16), .PC_W(16), .RD_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_fc = 2'b00; bus.func_c = 4'h0;
    bus.in_op = '0; bus.in_r0 = '0; bus.in_flag = 1'b0; bus.in_oflw = 1'b0;
    bus.in_rd = '0; bus.in_sdata = '0; bus.in_tgt = '0; bus.in_pc = '0;
  endtask

  task automatic ex(input logic [1:0] fc, input logic [3:0] fn, input logic [15:0] op,
                    input logic [15:0] r0, input logic flag, input logic oflw,
                    input logic [3:0] rd, input logic [15:0] sdata,
                    input logic [15:0] tgt, input logic [15:0] pc);
    bus.in_valid = 1'b1; bus.in_fc = fc; bus.func_c = fn; bus.in_op = op;
    bus.in_r0 = r0; bus.in_flag = flag; bus.in_oflw = oflw; bus.in_rd = rd;
    bus.in_sdata = sdata; bus.in_tgt = tgt; bus.in_pc = pc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  {31'd0, bus.out_ready}, 32'd1);
    check({tag, "_valid"},  {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_result"}, {16'd0, bus.out_result}, 32'd0);
    check({tag, "_r0"},     {16'd0, bus.out_r0}, 32'd0);
    check({tag, "_en"},     {28'd0, bus.out_reg_we, bus.out_r0_we, bus.out_mem_rd, bus.out_mem_wr}, 32'd0);
    check({tag, "_rd"},     {28'd0, bus.out_rd}, 32'd0);
    check({tag, "_wdata"},  {16'd0, bus.out_wdata}, 32'd0);
    check({tag, "_redir"},  {30'd0, bus.out_redirect, bus.out_flush}, 32'd0);
    check({tag, "_tgt"},    {16'd0, bus.out_tgt}, 32'd0);
    check({tag, "_exc"},    {29'd0, bus.out_exc, bus.out_cause}, 32'd0);
    check({tag, "_epc"},    {16'd0, bus.out_epc}, 32'd0);
    check({tag, "_state"},  {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    idle();
    bus.mem_stall = 1'b0;
    bus.exc_ack   = 1'b0;
    step(); step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // A-type add, no overflow
    ex(2'b00, 4'b0000, 16'h0005, 16'h0000, 1'b0, 1'b0, 4'd3, 16'h0, 16'h0, 16'h0010);
    step();
    check("add_valid",  {31'd0, bus.out_valid}, 32'd1);
    check("add_reg_we", {31'd0, bus.out_reg_we}, 32'd1);
    check("add_result", {16'd0, bus.out_result}, 32'h0005);
    check("add_rd",     {28'd0, bus.out_rd}, 32'd3);
    check("add_r0_we",  {31'd0, bus.out_r0_we}, 32'd0);

    // divide: result plus R0 write
    ex(2'b00, 4'b0101, 16'h0003, 16'h0001, 1'b0, 1'b0, 4'd4, 16'h0, 16'h0, 16'h0011);
    step();
    check("div_reg_we", {31'd0, bus.out_reg_we}, 32'd1);
    check("div_r0_we",  {31'd0, bus.out_r0_we}, 32'd1);
    check("div_r0",     {16'd0, bus.out_r0}, 32'h0001);
    check("div_result", {16'd0, bus.out_result}, 32'h0003);

    // overflow ignored for 0010
    ex(2'b00, 4'b0010, 16'h7fff, 16'h0, 1'b0, 1'b1, 4'd6, 16'h0, 16'h0, 16'h0012);
    step();
    check("ign_ovf_reg_we", {31'd0, bus.out_reg_we}, 32'd1);
    check("ign_ovf_exc",    {31'd0, bus.out_exc}, 32'd0);

    // bubble, with a stray exc_ack in RUN
    idle();
    bus.exc_ack = 1'b1;
    step();
    bus.exc_ack = 1'b0;
    check("bubble_valid",  {31'd0, bus.out_valid}, 32'd0);
    check("bubble_reg_we", {31'd0, bus.out_reg_we}, 32'd0);
    check("bubble_state",  {30'd0, dbg_state}, 32'd0);

    // not-taken branch
    ex(2'b10, 4'b0001, 16'h0, 16'h0, 1'b0, 1'b0, 4'd1, 16'h0, 16'h0080, 16'h0013);
    step();
    check("nt_valid", {31'd0, bus.out_valid}, 32'd1);
    check("nt_redir", {30'd0, bus.out_redirect, bus.out_flush}, 32'd0);
    check("nt_ready", {31'd0, bus.out_ready}, 32'd1);

    // taken branch: one-cycle redirect/flush, next EX dropped
    ex(2'b10, 4'b0010, 16'h0, 16'h0, 1'b1, 1'b0, 4'd1, 16'h0, 16'h0040, 16'h0014);
    step();
    check("br_redirect", {31'd0, bus.out_redirect}, 32'd1);
    check("br_flush",    {31'd0, bus.out_flush}, 32'd1);
    check("br_tgt",      {16'd0, bus.out_tgt}, 32'h0040);
    check("br_writes",   {28'd0, bus.out_reg_we, bus.out_r0_we, bus.out_mem_rd, bus.out_mem_wr}, 32'd0);
    check("br_ready",    {31'd0, bus.out_ready}, 32'd0);
    check("br_state",    {30'd0, dbg_state}, 32'd1);
    ex(2'b00, 4'b0000, 16'h0077, 16'h0, 1'b0, 1'b0, 4'd5, 16'h0, 16'h0, 16'h0015);
    step();
    check("fl_redirect", {30'd0, bus.out_redirect, bus.out_flush}, 32'd0);
    check("fl_drop_valid",  {31'd0, bus.out_valid}, 32'd0);
    check("fl_drop_reg_we", {31'd0, bus.out_reg_we}, 32'd0);
    check("fl_ready",    {31'd0, bus.out_ready}, 32'd1);

    // overflow exception, held 5 cycles, then acknowledged
    ex(2'b00, 4'b0001, 16'h8000, 16'h0, 1'b0, 1'b1, 4'd2, 16'h0, 16'h0, 16'h0012);
    step();
    check("ovf_exc",    {31'd0, bus.out_exc}, 32'd1);
    check("ovf_cause",  {30'd0, bus.out_cause}, 32'd1);
    check("ovf_epc",    {16'd0, bus.out_epc}, 32'h0012);
    check("ovf_reg_we", {31'd0, bus.out_reg_we}, 32'd0);
    check("ovf_valid",  {31'd0, bus.out_valid}, 32'd1);
    check("ovf_flush",  {31'd0, bus.out_flush}, 32'd1);
    idle();
    for (int i = 0; i < 5; i++) begin
      step();
      check("exc_hold_exc",   {31'd0, bus.out_exc}, 32'd1);
      check("exc_hold_epc",   {16'd0, bus.out_epc}, 32'h0012);
      check("exc_hold_valid", {31'd0, bus.out_valid}, 32'd0);
      check("exc_hold_flush", {31'd0, bus.out_flush}, 32'd0);
      check("exc_hold_ready", {31'd0, bus.out_ready}, 32'd0);
    end
    bus.exc_ack = 1'b1;
    step();
    bus.exc_ack = 1'b0;
    check("ack_exc",   {31'd0, bus.out_exc}, 32'd0);
    check("ack_ready", {31'd0, bus.out_ready}, 32'd1);

    // load, then a store held behind a 3-cycle MEM stall
    ex(2'b01, 4'b0000, 16'h0100, 16'h0, 1'b0, 1'b0, 4'd2, 16'h0, 16'h0, 16'h0020);
    step();
    check("lw_mem_rd", {31'd0, bus.out_mem_rd}, 32'd1);
    check("lw_reg_we", {31'd0, bus.out_reg_we}, 32'd1);
    ex(2'b01, 4'b0001, 16'h0200, 16'h0, 1'b0, 1'b0, 4'd0, 16'hbeef, 16'h0, 16'h0021);
    bus.mem_stall = 1'b1;
    #1;
    check("stall_ready", {31'd0, bus.out_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_mem_rd", {31'd0, bus.out_mem_rd}, 32'd1);
      check("stall_mem_wr", {31'd0, bus.out_mem_wr}, 32'd0);
      check("stall_result", {16'd0, bus.out_result}, 32'h0100);
      check("stall_ready2", {31'd0, bus.out_ready}, 32'd0);
    end
    bus.mem_stall = 1'b0;
    step();
    check("sw_mem_wr", {31'd0, bus.out_mem_wr}, 32'd1);
    check("sw_wdata",  {16'd0, bus.out_wdata}, 32'hbeef);
    check("sw_result", {16'd0, bus.out_result}, 32'h0200);
    check("sw_reg_we", {31'd0, bus.out_reg_we}, 32'd0);
    check("sw_mem_rd", {31'd0, bus.out_mem_rd}, 32'd0);

    // reserved class -> illegal, then reset during EXC
    ex(2'b11, 4'b0000, 16'h0, 16'h0, 1'b0, 1'b0, 4'd1, 16'h0, 16'h0, 16'h0034);
    step();
    check("ill_exc",   {31'd0, bus.out_exc}, 32'd1);
    check("ill_cause", {30'd0, bus.out_cause}, 32'd2);
    check("ill_epc",   {16'd0, bus.out_epc}, 32'h0034);
    check("ill_state", {30'd0, dbg_state}, 32'd2);
    idle();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("exc_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
